alu_exec_unit: RTL and testbench

//  Parametrised, registered EX-stage ALU with valid/ready handshake on both sides, plus an architectural flag register (Z,V,N).

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_paddsb.sv | 26 ++
 rtl/alu_exec_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: opcode encodings, flag bit
// positions, shift FSM states and the signed-saturation helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam logic [3:0] OP_LW     = 4'd8;
  localparam logic [3:0] OP_SW     = 4'd9;
  localparam logic [3:0] OP_LHB    = 4'd10;
  localparam logic [3:0] OP_LLB    = 4'd11;
  localparam logic [3:0] OP_HLT    = 4'd15;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_t;

  // Signed-add overflow detection from the operand and raw-sum sign bits.
  // Returns {overflow, saturate_positive}; when overflow is set the caller
  // substitutes the most positive value if saturate_positive, else the most
  // negative one. For subtraction pass the inverted sign of the subtrahend.
  function automatic logic [1:0] sat_add(input logic sign_a,
                                         input logic sign_b,
                                         input logic sign_sum);
    logic ovf;
    ovf = (sign_a == sign_b) && (sign_sum != sign_a);
    return {ovf, ~sign_a};
  endfunction

endpackage

// File: rtl/alu_paddsb.sv
// Lane-parallel signed saturating adder: WIDTH/LANE independent LANE-bit
// lanes, each clamped to its own signed range on overflow.
module alu_paddsb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam logic [LANE-1:0] LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0] LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  for (genvar gi = 0; gi < WIDTH / LANE; gi++) begin : g_lane
    logic [LANE-1:0] raw;
    logic [1:0]      sat;

    assign raw = a[gi*LANE +: LANE] + b[gi*LANE +: LANE];
    assign sat = sat_add(a[gi*LANE+LANE-1], b[gi*LANE+LANE-1], raw[LANE-1]);
    assign sum[gi*LANE +: LANE] = sat[1] ? (sat[0] ? LANE_MAX : LANE_MIN) : raw;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU with valid/ready on both sides and a {Z,V,N}
// flag register that loads together with the result.
// Optional build macro ALU_ITER_SHIFT_EN: shifts use a 1-bit-per-cycle
// iterative shifter (latency = shift amount); otherwise a barrel shifter
// gives single-cycle latency for every opcode.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       flags
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int NBYTES = WIDTH / 8;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_result_reg;
  logic [2:0]       flags_reg;

  logic             out_free;
  logic             accept;
  logic             single_done;
  logic             complete;
  logic [WIDTH-1:0] complete_result;
  logic [2:0]       complete_flags;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [1:0]       add_sat;
  logic [1:0]       sub_sat;
  logic [WIDTH-1:0] paddsb_res;
  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] op_res;
  logic [2:0]       op_flags;
  logic [WIDTH-1:0] byte_ext [2*NBYTES];

  assign out_free = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;
  assign shamt    = in_b[SHW-1:0];

  assign add_sum  = in_a + in_b;
  assign sub_diff = in_a - in_b;
  assign add_sat  = sat_add(in_a[WIDTH-1], in_b[WIDTH-1], add_sum[WIDTH-1]);
  assign sub_sat  = sat_add(in_a[WIDTH-1], ~in_b[WIDTH-1], sub_diff[WIDTH-1]);

  alu_paddsb #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_paddsb (
    .a   (in_a),
    .b   (in_b),
    .sum (paddsb_res)
  );

  // Sign-extend every byte of both operands for the reduction sum
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_red
    assign byte_ext[2*gi]   = {{(WIDTH-8){in_a[8*gi+7]}}, in_a[8*gi +: 8]};
    assign byte_ext[2*gi+1] = {{(WIDTH-8){in_b[8*gi+7]}}, in_b[8*gi +: 8]};
  end

  // Reduction: sum of all sign-extended bytes, modulo 2^WIDTH
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < 2 * NBYTES; i++) begin
      red_sum = red_sum + byte_ext[i];
    end
  end

`ifdef ALU_ITER_SHIFT_EN
  alu_state_t       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [3:0]       shop_reg;
  logic             start_iter;
  logic             cnt_le1;
  logic             iter_done;
  logic [WIDTH-1:0] iter_final;

  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] val);
    case (op)
      OP_SLL:  return {val[WIDTH-2:0], 1'b0};
      OP_SRA:  return {val[WIDTH-1], val[WIDTH-1:1]};
      default: return {val[0], val[WIDTH-1:1]};
    endcase
  endfunction

  // Shifts by 0 or 1 finish through the single-cycle path; longer ones
  // take the first step at accept and iterate the rest in ST_SHIFT.
  assign start_iter  = accept & ((in_op == OP_SLL) | (in_op == OP_SRA) | (in_op == OP_ROR))
                     & (shamt[SHW-1:1] != '0);
  assign single_done = accept & ~start_iter;
  assign shift_res   = shamt[0] ? shift_one(in_op, in_a) : in_a;
  assign cnt_le1     = (cnt_reg[SHW-1:1] == '0);
  // cnt_reg==0 means the final value is already parked waiting for space
  assign iter_final  = cnt_reg[0] ? shift_one(shop_reg, shift_reg) : shift_reg;
  assign iter_done   = (state_reg == ST_SHIFT) & cnt_le1 & out_free;
  assign in_ready    = (state_reg == ST_IDLE) & out_free;

  // Iterative shift FSM: one bit per cycle, park the result if blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      shop_reg  <= OP_SLL;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_iter) begin
            state_reg <= ST_SHIFT;
            shift_reg <= shift_one(in_op, in_a);
            cnt_reg   <= shamt - 1'b1;
            shop_reg  <= in_op;
          end
        end
        default: begin
          if (cnt_le1) begin
            shift_reg <= iter_final;
            cnt_reg   <= '0;
            if (out_free) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            shift_reg <= shift_one(shop_reg, shift_reg);
            cnt_reg   <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  // Select between an iterative-shift completion and a single-cycle one
  always_comb begin
    complete_result = op_res;
    complete_flags  = op_flags;
    if (iter_done) begin
      complete_result        = iter_final;
      complete_flags         = flags_reg;
      complete_flags[FLG_Z]  = (iter_final == '0);
    end
  end

  assign complete = single_done | iter_done;
`else
  // Barrel shifter: every shift amount completes in one cycle
  always_comb begin
    shift_res = in_a;
    case (in_op)
      OP_SLL:  shift_res = in_a << shamt;
      OP_SRA:  shift_res = $signed(in_a) >>> shamt;
      default: shift_res = WIDTH'({in_a, in_a} >> shamt);
    endcase
  end

  assign single_done     = accept;
  assign in_ready        = out_free;
  assign complete        = single_done;
  assign complete_result = op_res;
  assign complete_flags  = op_flags;
`endif

  // Opcode decode: result and the flag vector to load with it
  always_comb begin
    op_res   = in_a;
    op_flags = flags_reg;
    case (in_op)
      OP_ADD: begin
        op_res          = add_sat[1] ? (add_sat[0] ? SAT_MAX : SAT_MIN) : add_sum;
        op_flags[FLG_Z] = (op_res == '0);
        op_flags[FLG_V] = add_sat[1];
        op_flags[FLG_N] = op_res[WIDTH-1];
      end
      OP_SUB: begin
        op_res          = sub_sat[1] ? (sub_sat[0] ? SAT_MAX : SAT_MIN) : sub_diff;
        op_flags[FLG_Z] = (op_res == '0);
        op_flags[FLG_V] = sub_sat[1];
        op_flags[FLG_N] = op_res[WIDTH-1];
      end
      OP_XOR: begin
        op_res          = in_a ^ in_b;
        op_flags[FLG_Z] = (op_res == '0);
      end
      OP_RED:    op_res = red_sum;
      OP_SLL, OP_SRA, OP_ROR: begin
        op_res          = shift_res;
        op_flags[FLG_Z] = (op_res == '0);
      end
      OP_PADDSB: op_res = paddsb_res;
      OP_LW, OP_SW: op_res = add_sum;
      OP_LHB:    op_res = {in_b[7:0], in_a[WIDTH-9:0]};
      OP_LLB:    op_res = {in_a[WIDTH-1:8], in_b[7:0]};
      default:   op_res = in_a;
    endcase
  end

  // Result/flag register: load on completion, drop valid on consumption
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      flags_reg      <= 3'b000;
    end else if (complete) begin
      out_valid_reg  <= 1'b1;
      out_result_reg <= complete_result;
      flags_reg      <= complete_flags;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign flags      = flags_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=16, LANE=4): directed
// cases with known answers, then random traffic against a queue-based
// reference model with random back-pressure.
module tb_alu_exec_unit;

  localparam int WIDTH = 16;
  localparam int NRAND = 400;
`ifdef ALU_ITER_SHIFT_EN
  localparam int LAT_SLL15 = 15;
  localparam int LAT_SRA4  = 4;
`else
  localparam int LAT_SLL15 = 1;
  localparam int LAT_SRA4  = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .LANE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural semantics computed with plain integer math
  task automatic ref_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] fin, output logic [15:0] res, output logic [2:0] fout);
    int sa, sb, s, sh, l;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sh   = int'(b[3:0]);
    res  = a;
    fout = fin;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sa + sb : sa - sb;
        if (s > 32767)       res = 16'h7FFF;
        else if (s < -32768) res = 16'h8000;
        else                 res = s[15:0];
        fout = {res == 16'h0, (s > 32767) || (s < -32768), res[15]};
      end
      4'd2: begin res = a ^ b; fout[2] = (res == 16'h0); end
      4'd3: begin
        s = 0;
        for (int i = 0; i < 2; i++) begin
          s = s + int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
        end
        res = s[15:0];
      end
      4'd4: begin res = a << sh; fout[2] = (res == 16'h0); end
      4'd5: begin res = 16'(sa >>> sh); fout[2] = (res == 16'h0); end
      4'd6: begin res = (a >> sh) | (a << (16 - sh)); fout[2] = (res == 16'h0); end
      4'd7: begin
        res = 16'h0;
        for (int i = 0; i < 4; i++) begin
          l = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
          if (l > 7)  l = 7;
          if (l < -8) l = -8;
          res[4*i +: 4] = l[3:0];
        end
      end
      4'd8, 4'd9: res = a + b;
      4'd10: res = {b[7:0], a[7:0]};
      4'd11: res = {a[15:8], b[7:0]};
      default: res = a;
    endcase
  endtask

  // Offer one op with out_ready as set by caller; return cycles to out_valid
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    int guard;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [2:0] exp_flg, input int exp_lat);
    int lat;
    issue(op, a, b, lat);
    $display("%s: op=%0d a=%h b=%h -> res=%h flags=%b lat=%0d", name, op, a, b,
             out_result, flags, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, out_result, exp_res);
    check({name, "_flags"}, flags, exp_flg);
    step();
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'(32'($urandom_range(0, 15)));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int          accepted, cycles, lat;
    logic        held_prev, seen_valid;
    logic [15:0] prev_res, m_res;
    logic [2:0]  prev_flg, m_flags, m_fout;
    logic [18:0] exp_q[$];
    logic [18:0] exp_e;

    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", flags, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    run_op("add_sat", 4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 1);
    run_op("sub_sat", 4'd1, 16'h8000, 16'h0001, 16'h8000, 3'b011, 1);
    run_op("xor_zero", 4'd2, 16'h1234, 16'h1234, 16'h0000, 3'b111, 1);
    run_op("paddsb", 4'd7, 16'h7F12, 16'h0177, 16'h7077, 3'b111, 1);
    run_op("red", 4'd3, 16'h0102, 16'h0304, 16'h000A, 3'b111, 1);

    // Back-pressure: result and flags must hold while out_ready is low
    out_ready = 1'b0;
    issue(4'd0, 16'h0002, 16'h0003, lat);
    check("hold_lat", lat, 1);
    in_valid = 1'b1; in_op = 4'd8; in_a = 16'h0100; in_b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("hold cycle %0d: valid=%b res=%h flags=%b in_ready=%b", i, out_valid,
               out_result, flags, in_ready);
      check("hold_valid", out_valid, 1);
      check("hold_res", out_result, 16'h0005);
      check("hold_flags", flags, 3'b000);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a = 16'(k * 16);
      #1;
      check("b2b_ready", in_ready, 1);
      step();
      $display("b2b %0d: res=%h flags=%b", k, out_result, flags);
      check("b2b_valid", out_valid, 1);
      check("b2b_res", out_result, 16'(k * 16 + 1));
      check("b2b_flags", flags, 3'b000);
    end
    in_valid = 1'b0;
    step();

    run_op("sll15", 4'd4, 16'h0001, 16'd15, 16'h8000, 3'b000, LAT_SLL15);
    run_op("sra4", 4'd5, 16'h8000, 16'd4, 16'hF800, 3'b000, LAT_SRA4);
    run_op("ror0", 4'd6, 16'h0000, 16'd0, 16'h0000, 3'b100, 1);
    run_op("sll1", 4'd4, 16'h0003, 16'd1, 16'h0006, 3'b000, 1);
    run_op("xor_z", 4'd2, 16'h0005, 16'h0005, 16'h0000, 3'b100, 1);

    // Reset in the middle of a long shift
    in_op = 4'd4; in_a = 16'h0001; in_b = 16'd15; in_valid = 1'b1;
    #1;
    check("abort_accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("abort: valid=%b flags=%b in_ready=%b", out_valid, flags, in_ready);
    check("abort_valid", out_valid, 0);
    check("abort_flags", flags, 3'b000);
    check("abort_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", seen_valid, 0);
    run_op("lw_wrap", 4'd8, 16'hFFFF, 16'h0002, 16'h0001, 3'b000, 1);

    // Random traffic against the reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_flags = 3'b000;
    accepted = 0; cycles = 0; held_prev = 1'b0; prev_res = '0; prev_flg = '0;
    while ((accepted < NRAND || exp_q.size() > 0) && cycles < 30000) begin
      in_valid  = (accepted < NRAND) && ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = rand_operand();
      in_b      = rand_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held_prev) begin
        check("rand_hold_valid", out_valid, 1);
        check("rand_hold_res", out_result, prev_res);
        check("rand_hold_flags", flags, prev_flg);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          $display("rand out: res=%h flags=%b exp_res=%h exp_flags=%b", out_result, flags,
                   exp_e[18:3], exp_e[2:0]);
          check("rand_res", out_result, exp_e[18:3]);
          check("rand_flags", flags, exp_e[2:0]);
        end
      end
      if (in_valid && in_ready) begin
        ref_exec(in_op, in_a, in_b, m_flags, m_res, m_fout);
        m_flags = m_fout;
        exp_q.push_back({m_res, m_fout});
        accepted++;
      end
      held_prev = out_valid && !out_ready;
      prev_res  = out_result;
      prev_flg  = flags;
      step();
      cycles++;
    end
    if (accepted < NRAND || exp_q.size() > 0) check("rand_drain_timeout", 0, 1);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
